// File: rtl/player_sprite_renderer.sv
// Player sprite renderer: latches the player position at vblank entry, pulses frame_start,
// and produces a 2-cycle-latency sprite pixel. Optional SPRITE_BLINK_EN blinks the sprite on game over.
module player_sprite_renderer #(
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter int          SPRITE_W   = 16,
    parameter int          SPRITE_H   = 16,
    parameter int          INIT_X     = 100,
    parameter int          INIT_Y     = 450,
    parameter logic [23:0] HEAD_COLOR = 24'hFFC080,
    parameter logic [23:0] BODY_COLOR = 24'h0000FF,
    localparam int         XW         = $clog2(H_ACTIVE),
    localparam int         YW         = $clog2(V_ACTIVE)
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic [XW-1:0] pix_x,
    input  logic [YW-1:0] pix_y,
    input  logic          pix_valid,
    input  logic [1:0]    gameState,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic          frame_start,
    output logic          sprite_on,
    output logic [23:0]   sprite_rgb
);

    localparam logic [YW:0]   V_LIM     = (YW+1)'(V_ACTIVE);
    localparam logic [XW:0]   SPR_W_C   = (XW+1)'(SPRITE_W);
    localparam logic [YW:0]   SPR_H_C   = (YW+1)'(SPRITE_H);
    localparam logic [YW-1:0] HEAD_Y_HI = YW'(SPRITE_H / 4);
    localparam logic [XW-1:0] HEAD_X_LO = XW'(SPRITE_W / 4);
    localparam logic [XW-1:0] HEAD_X_HI = XW'(3 * SPRITE_W / 4);
    localparam logic [XW-1:0] BODY_X_LO = XW'(SPRITE_W / 8);
    localparam logic [XW-1:0] BODY_X_HI = XW'(7 * SPRITE_W / 8);
    localparam logic [XW-1:0] INIT_X_C  = XW'(INIT_X);
    localparam logic [YW-1:0] INIT_Y_C  = YW'(INIT_Y);

    logic          vblank_s;
    logic          vblank_prev_q, vblank_prev_d;
    logic          frame_start_q, frame_start_d;
    logic [XW-1:0] x_l_q, x_l_d;
    logic [YW-1:0] y_l_q, y_l_d;
    logic [XW:0]   x_end_s;
    logic [YW:0]   y_end_s;
    logic          in_box_s;
    logic          s1_in_box_q, s1_in_box_d;
    logic [XW-1:0] s1_dx_q, s1_dx_d;
    logic [YW-1:0] s1_dy_q, s1_dy_d;
    logic          sprite_on_q, sprite_on_d;
    logic [23:0]   sprite_rgb_q, sprite_rgb_d;
`ifdef SPRITE_BLINK_EN
    logic [4:0]    blink_cnt_q, blink_cnt_d;
`endif

    // Frame-boundary detection, position latch and stage-1 hit test.
    always_comb begin
        vblank_s      = ({1'b0, pix_y} >= V_LIM);
        vblank_prev_d = vblank_s;
        frame_start_d = vblank_s && !vblank_prev_q;
        x_l_d         = x_l_q;
        y_l_d         = y_l_q;
        if (frame_start_q) begin
            x_l_d = x;
            y_l_d = y;
        end else begin
            x_l_d = x_l_q;
            y_l_d = y_l_q;
        end
        // One bit wider so a sprite near the right/bottom edge clips instead of wrapping.
        x_end_s  = {1'b0, x_l_q} + SPR_W_C;
        y_end_s  = {1'b0, y_l_q} + SPR_H_C;
        in_box_s = pix_valid && (gameState != 2'b00)
                   && (pix_x >= x_l_q) && ({1'b0, pix_x} < x_end_s)
                   && (pix_y >= y_l_q) && ({1'b0, pix_y} < y_end_s);
`ifdef SPRITE_BLINK_EN
        blink_cnt_d = frame_start_q ? (blink_cnt_q + 5'd1) : blink_cnt_q;
        if ((gameState == 2'b10) && blink_cnt_q[4]) begin
            in_box_s = 1'b0;
        end else begin
            in_box_s = in_box_s;
        end
`endif
        s1_in_box_d = in_box_s;
        s1_dx_d     = pix_x - x_l_q;
        s1_dy_d     = pix_y - y_l_q;
    end

    // Stage-2 bitmap lookup: head in the top quarter, wider body below.
    always_comb begin
        sprite_on_d  = 1'b0;
        sprite_rgb_d = 24'h000000;
        if (s1_in_box_q) begin
            if (s1_dy_q < HEAD_Y_HI) begin
                if ((s1_dx_q >= HEAD_X_LO) && (s1_dx_q < HEAD_X_HI)) begin
                    sprite_on_d  = 1'b1;
                    sprite_rgb_d = HEAD_COLOR;
                end else begin
                    sprite_on_d  = 1'b0;
                    sprite_rgb_d = 24'h000000;
                end
            end else if ((s1_dx_q >= BODY_X_LO) && (s1_dx_q < BODY_X_HI)) begin
                sprite_on_d  = 1'b1;
                sprite_rgb_d = BODY_COLOR;
            end else begin
                sprite_on_d  = 1'b0;
                sprite_rgb_d = 24'h000000;
            end
        end else begin
            sprite_on_d  = 1'b0;
            sprite_rgb_d = 24'h000000;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            vblank_prev_q <= 1'b0;
            frame_start_q <= 1'b0;
            x_l_q         <= INIT_X_C;
            y_l_q         <= INIT_Y_C;
            s1_in_box_q   <= 1'b0;
            s1_dx_q       <= '0;
            s1_dy_q       <= '0;
            sprite_on_q   <= 1'b0;
            sprite_rgb_q  <= 24'h000000;
`ifdef SPRITE_BLINK_EN
            blink_cnt_q   <= 5'd0;
`endif
        end else begin
            vblank_prev_q <= vblank_prev_d;
            frame_start_q <= frame_start_d;
            x_l_q         <= x_l_d;
            y_l_q         <= y_l_d;
            s1_in_box_q   <= s1_in_box_d;
            s1_dx_q       <= s1_dx_d;
            s1_dy_q       <= s1_dy_d;
            sprite_on_q   <= sprite_on_d;
            sprite_rgb_q  <= sprite_rgb_d;
`ifdef SPRITE_BLINK_EN
            blink_cnt_q   <= blink_cnt_d;
`endif
        end
    end

    assign frame_start = frame_start_q;
    assign sprite_on   = sprite_on_q;
    assign sprite_rgb  = sprite_rgb_q;

endmodule

// File: tb/tb_player_sprite_renderer.sv
// Self-checking bench for player_sprite_renderer: directed scenarios plus random stimulus,
// every cycle compared against a pixel-level reference model.
module tb_player_sprite_renderer;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  pix_x = 10'd0;
    logic [8:0]  pix_y = 9'd200;
    logic        pix_valid = 1'b0;
    logic [1:0]  gameState = 2'b00;
    logic [9:0]  x = 10'd100;
    logic [8:0]  y = 9'd450;
    logic        frame_start;
    logic        sprite_on;
    logic [23:0] sprite_rgb;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    bit m_prev_vb = 0;
    bit m_fs = 0;
    int m_xl = 100, m_yl = 450, m_cnt = 0;
    int m_d1 = 0, m_out = 0;

    player_sprite_renderer dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
        .pix_valid(pix_valid), .gameState(gameState), .x(x), .y(y),
        .frame_start(frame_start), .sprite_on(sprite_on), .sprite_rgb(sprite_rgb)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Colour the sprite shows at a pixel (0 = transparent), straight from the shape rules.
    function automatic int pixel_model(int px, int py, bit pv, int gs, int xl, int yl, int cnt);
        int dx, dy;
        if (!pv || gs == 0) return 0;
`ifdef SPRITE_BLINK_EN
        if (gs == 2 && cnt >= 16) return 0;
`endif
        if (px < xl || px >= xl + 16 || py < yl || py >= yl + 16) return 0;
        dx = px - xl;
        dy = py - yl;
        if (dy < 4) return (dx >= 4 && dx < 12) ? 32'hFFC080 : 0;
        return (dx >= 2 && dx < 14) ? 32'h0000FF : 0;
    endfunction

    // Advance one clock, update the model from the inputs seen at that edge, compare outputs.
    task automatic tick();
        bit vb;
        @(posedge CLOCK_50);
        vb = (pix_y >= 480);
        if (reset) begin
            m_prev_vb = 0; m_fs = 0; m_xl = 100; m_yl = 450; m_cnt = 0;
            m_d1 = 0; m_out = 0;
        end else begin
            m_out = m_d1;
            m_d1  = pixel_model(pix_x, pix_y, pix_valid, gameState, m_xl, m_yl, m_cnt);
            if (m_fs) begin
                m_xl = x; m_yl = y; m_cnt = (m_cnt + 1) % 32;
            end
            m_fs = vb && !m_prev_vb;
            m_prev_vb = vb;
        end
        #1;
        chk("frame_start", frame_start, m_fs);
        chk("sprite_on", sprite_on, m_out != 0);
        chk("sprite_rgb", sprite_rgb, m_out);
    endtask

    task automatic probe(string nm, int px, int py, bit pv, logic [23:0] exp);
        pix_x = 10'(px); pix_y = 9'(py); pix_valid = pv;
        tick(); tick();
        chk(nm, sprite_rgb, exp);
    endtask

    task automatic new_frame();
        pix_y = 9'd479; tick();
        pix_y = 9'd480; tick(); tick();
        pix_y = 9'd200; tick();
    endtask

    initial begin
        int pulses, first;
        logic [23:0] e;

        // 1: reset mid-frame, then scan the head row at the initial position
        reset = 1'b1; pix_y = 9'd200; pix_valid = 1'b1; gameState = 2'b01;
        tick(); tick(); tick();
        chk("reset_fs", frame_start, 1'b0);
        chk("reset_on", sprite_on, 1'b0);
        chk("reset_rgb", sprite_rgb, 24'h0);
        reset = 1'b0;
        pix_y = 9'd450;
        for (int c = 100; c < 116; c++) begin
            pix_x = 10'(c); tick();
        end
        probe("init_head", 104, 450, 1'b1, 24'hFFC080);
        probe("init_corner", 100, 450, 1'b1, 24'h0);

        // 2: single frame_start pulse during a long vblank
        pix_y = 9'd479; tick();
        pix_y = 9'd480; pulses = 0; first = -1;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (frame_start) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        chk("fs_count", pulses, 1);
        chk("fs_first", first, 0);

        // 3: new position takes effect only after frame_start
        x = 10'd200; y = 9'd100;
        probe("old_pos", 104, 450, 1'b1, 24'hFFC080);
        new_frame();
        probe("mv_head", 204, 100, 1'b1, 24'hFFC080);
        probe("mv_body", 202, 104, 1'b1, 24'h0000FF);
        probe("mv_corner", 200, 100, 1'b1, 24'h0);
        probe("mv_right", 216, 104, 1'b1, 24'h0);

        // 4: clipping at the right and bottom edges
        x = 10'd630; y = 9'd470;
        new_frame();
        probe("clip_body", 639, 475, 1'b1, 24'h0000FF);
        probe("clip_nowrap_x", 0, 475, 1'b1, 24'h0);
        probe("clip_nowrap_x2", 5, 470, 1'b1, 24'h0);
        probe("clip_bottom", 635, 479, 1'b1, 24'h0000FF);

        // 5: idle state and invalid pixels suppress drawing; state toggle latency
        x = 10'd100; y = 9'd450;
        new_frame();
        gameState = 2'b00;
        probe("idle_off", 104, 450, 1'b1, 24'h0);
        gameState = 2'b01;
        probe("invalid_off", 104, 450, 1'b0, 24'h0);
        gameState = 2'b00; pix_valid = 1'b1;
        tick(); tick();
        gameState = 2'b01;
        tick();
        chk("toggle_1cyc", sprite_on, 1'b0);
        tick();
        chk("toggle_2cyc", sprite_on, 1'b1);

        // 6: game-over blinking across 33 frames
        reset = 1'b1; gameState = 2'b10; pix_y = 9'd200;
        tick(); tick();
        reset = 1'b0;
        for (int k = 0; k < 33; k++) begin
`ifdef SPRITE_BLINK_EN
            e = (((k / 16) % 2) == 1) ? 24'h0 : 24'hFFC080;
`else
            e = 24'hFFC080;
`endif
            probe("blink", 104, 450, 1'b1, e);
            new_frame();
        end

        // random stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            gameState = 2'($urandom_range(0, 3));
            pix_valid = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) pix_y = 9'($urandom_range(480, 511));
            else if ($urandom_range(0, 3) == 0) pix_y = 9'($urandom_range(0, 479));
            else pix_y = 9'((m_yl + $urandom_range(0, 20) + 508) % 512);
            if ($urandom_range(0, 3) == 0) pix_x = 10'($urandom_range(0, 1023));
            else pix_x = 10'((m_xl + $urandom_range(0, 20) + 1020) % 1024);
            if ($urandom_range(0, 31) == 0) begin
                x = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 639)) : 10'($urandom_range(620, 639));
                y = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 479)) : 9'($urandom_range(460, 479));
            end
            tick();
        end
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
